// File: rtl/mem_access_stage.sv
// MEM stage: one word req/ack data-bus transfer per load/store, stalling upstream until DONE.
// Optional ack timeout with bus_error, enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  PCsrc_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  Dest_Reg_Addr_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [1:0]  PCsrc_out,
    output logic [31:0] read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  Dest_Reg_Addr_out,
    output logic        misaligned_fault,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        access, aligned, mis_raw;

    assign access  = MemRead_in | MemWrite_in;
    assign aligned = (ALU_result_in[1:0] == 2'b00);

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timed_out_q, timed_out_d;
    logic       timeout_hit;
    assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        mis_raw = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            IDLE: begin
                if (access && aligned) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    addr_d  = ALU_result_in;
                    wdata_d = store_data_in;
                    we_d    = MemWrite_in;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_d       = 8'd0;
                    timed_out_d = 1'b0;
`endif
                end else if (access) begin
                    mis_raw = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d     = DONE;
                    rdata_d     = 32'd0;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                // The access still on the inputs belongs to the finished transfer.
                state_d = IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                timed_out_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= 8'd0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign bus_error = (state_q == DONE) && timed_out_q;
`else
    assign bus_error = 1'b0;
`endif

    // mem_req decodes from state, so an async reset drops it without a clock edge.
    assign mem_req           = (state_q == BUSY);
    assign mem_we            = we_q;
    assign mem_addr          = addr_q;
    assign mem_wdata         = wdata_q;
    assign read_data_out     = rdata_q;
    assign misaligned_fault  = mis_raw & ~reset;
    assign RegWrite_out      = RegWrite_in & ~mis_raw & ~bus_error;
    assign MemtoReg_out      = MemtoReg_in;
    assign PCsrc_out         = PCsrc_in;
    assign ALU_result_out    = ALU_result_in;
    assign Dest_Reg_Addr_out = Dest_Reg_Addr_in;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; timeout steps run only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [1:0]  PCsrc_in;
    logic [31:0] ALU_result_in, store_data_in;
    logic [4:0]  Dest_Reg_Addr_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall, RegWrite_out, MemtoReg_out;
    logic [1:0]  PCsrc_out;
    logic [31:0] read_data_out, ALU_result_out;
    logic [4:0]  Dest_Reg_Addr_out;
    logic        misaligned_fault, bus_error;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .PCsrc_in(PCsrc_in), .ALU_result_in(ALU_result_in),
        .store_data_in(store_data_in), .Dest_Reg_Addr_in(Dest_Reg_Addr_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .PCsrc_out(PCsrc_out),
        .read_data_out(read_data_out), .ALU_result_out(ALU_result_out),
        .Dest_Reg_Addr_out(Dest_Reg_Addr_out),
        .misaligned_fault(misaligned_fault), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        RegWrite_in = 1'b0; MemtoReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
        PCsrc_in = 2'b00; ALU_result_in = 32'd0; store_data_in = 32'd0; Dest_Reg_Addr_in = 5'd0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear_in(); mem_ack = 1'b0; mem_rdata = 32'd0;
        #2;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", read_data_out, 0);
        chk("rst_fault", misaligned_fault, 0);
        chk("rst_buserr", bus_error, 0);
        step(); reset = 1'b0;

        // Load at 0x100, ack two cycles after req rises
        RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; ALU_result_in = 32'h100;
        Dest_Reg_Addr_in = 5'd3; PCsrc_in = 2'b01;
        @(negedge clock);
        chk("ld_c0_stall", stall, 1); chk("ld_c0_req", mem_req, 0); chk("ld_pcsrc", PCsrc_out, 1);
        step(); @(negedge clock);
        chk("ld_c1_req", mem_req, 1); chk("ld_c1_addr", mem_addr, 32'h100);
        chk("ld_c1_we", mem_we, 0); chk("ld_c1_stall", stall, 1);
        step(); @(negedge clock);
        chk("ld_c2_req", mem_req, 1); chk("ld_c2_stall", stall, 1);
        step(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("ld_c3_req", mem_req, 1); chk("ld_c3_stall", stall, 1);
        step(); mem_ack = 0; mem_rdata = 32'd0;
        @(negedge clock);
        chk("ld_done_stall", stall, 0); chk("ld_done_req", mem_req, 0);
        chk("ld_done_rdata", read_data_out, 32'hDEADBEEF);
        chk("ld_done_regwr", RegWrite_out, 1); chk("ld_done_m2r", MemtoReg_out, 1);
        chk("ld_done_buserr", bus_error, 0);
        step();

        // Store at 0x204 with immediate ack, back-to-back after the load
        clear_in(); MemWrite_in = 1; ALU_result_in = 32'h204; store_data_in = 32'h12345678;
        @(negedge clock);
        chk("st_c0_stall", stall, 1); chk("st_c0_req", mem_req, 0);
        step(); mem_ack = 1; mem_rdata = 32'hBADBAD00;
        @(negedge clock);
        chk("st_c1_req", mem_req, 1); chk("st_c1_we", mem_we, 1);
        chk("st_c1_wdata", mem_wdata, 32'h12345678); chk("st_c1_addr", mem_addr, 32'h204);
        chk("st_c1_stall", stall, 1);
        step(); mem_ack = 0;
        @(negedge clock);
        chk("st_done_req", mem_req, 0); chk("st_done_stall", stall, 0);
        chk("st_done_rdata", read_data_out, 32'hDEADBEEF);
        step();

        // ALU instruction with a stray ack that must be ignored
        clear_in(); RegWrite_in = 1; ALU_result_in = 32'h55; Dest_Reg_Addr_in = 5'd7;
        PCsrc_in = 2'b10; mem_ack = 1; mem_rdata = 32'h11111111;
        @(negedge clock);
        chk("alu_stall", stall, 0); chk("alu_req", mem_req, 0);
        chk("alu_result", ALU_result_out, 32'h55); chk("alu_dest", Dest_Reg_Addr_out, 7);
        chk("alu_regwr", RegWrite_out, 1); chk("alu_pcsrc", PCsrc_out, 2);
        step(); mem_ack = 0;
        @(negedge clock);
        chk("alu_req2", mem_req, 0); chk("alu_rdata_kept", read_data_out, 32'hDEADBEEF);

        // Misaligned load at 0x102
        clear_in(); RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; ALU_result_in = 32'h102;
        @(negedge clock);
        chk("mis_fault", misaligned_fault, 1); chk("mis_req", mem_req, 0);
        chk("mis_stall", stall, 0); chk("mis_regwr", RegWrite_out, 0);
        step(); clear_in();
        @(negedge clock);
        chk("mis_fault_end", misaligned_fault, 0); chk("mis_req_end", mem_req, 0);

        // Reset asserted one cycle into BUSY
        RegWrite_in = 1; MemRead_in = 1; ALU_result_in = 32'h300;
        step(); @(negedge clock);
        chk("rb_req_busy", mem_req, 1);
        step(); reset = 1;
        #1;
        chk("rb_req_dropped", mem_req, 0); chk("rb_rdata", read_data_out, 0);
        chk("rb_addr", mem_addr, 0);
        step(); reset = 0; clear_in();
        @(negedge clock);
        chk("rb_idle_req", mem_req, 0); chk("rb_idle_stall", stall, 0);

        // Load after reset, ack one cycle after req, inputs held through DONE
        RegWrite_in = 1; MemRead_in = 1; ALU_result_in = 32'h108; Dest_Reg_Addr_in = 5'd9;
        @(negedge clock);
        chk("l2_c0_stall", stall, 1);
        step(); @(negedge clock);
        chk("l2_c1_req", mem_req, 1);
        step(); mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        chk("l2_c2_req", mem_req, 1);
        step(); mem_ack = 0;
        @(negedge clock);
        chk("l2_done_rdata", read_data_out, 32'hCAFEF00D); chk("l2_done_req", mem_req, 0);
        chk("l2_done_stall", stall, 0); chk("l2_done_regwr", RegWrite_out, 1);
        chk("l2_done_dest", Dest_Reg_Addr_out, 9);
        step(); @(negedge clock);
        chk("b2b_gap_req", mem_req, 0); chk("b2b_gap_stall", stall, 1);
        step(); mem_ack = 1; mem_rdata = 32'h0A0B0C0D;
        @(negedge clock);
        chk("b2b_req", mem_req, 1);
        step(); mem_ack = 0; clear_in();
        @(negedge clock);
        chk("b2b_done_rdata", read_data_out, 32'h0A0B0C0D); chk("b2b_done_req", mem_req, 0);
        step();

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack: abort after four BUSY cycles
        RegWrite_in = 1; MemRead_in = 1; ALU_result_in = 32'h400;
        @(negedge clock);
        chk("to_c0_stall", stall, 1);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clock);
            chk("to_busy_req", mem_req, 1);
        end
        step(); @(negedge clock);
        chk("to_buserr", bus_error, 1); chk("to_rdata", read_data_out, 0);
        chk("to_regwr", RegWrite_out, 0); chk("to_stall", stall, 0); chk("to_req", mem_req, 0);
        step(); clear_in();
        @(negedge clock);
        chk("to_buserr_end", bus_error, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage logic between the EX/MEM pipeline register and the MEM/WB pipeline register. It consumes the EX/MEM outputs: control bits, ALU result as address, store data and destination register. It runs a word-wide req/ack transaction on the data-memory bus and stalls the upstream pipeline until the transfer completes. It then presents write-back control, load data, ALU result and destination register to MEM/WB.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum BUSY cycles without ack before abort. Used only with `MEM_ACCESS_TIMEOUT_EN`. Range 2..255.

Ports:
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `RegWrite_in`, `MemtoReg_in`, `MemRead_in`, `MemWrite_in` in 1 each: control bits from EX/MEM.
- `PCsrc_in` in 2: branch select from EX/MEM. Passed through unchanged to `PCsrc_out` out 2.
- `ALU_result_in` in 32: address or arithmetic result.
- `store_data_in` in 32: write data.
- `Dest_Reg_Addr_in` in 5: destination register.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: transfer complete.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `stall` out 1: holds EX/MEM and all earlier stages. Drives EX/MEM `write` low.
- `RegWrite_out`, `MemtoReg_out` out 1 each: to MEM/WB.
- `read_data_out` out 32: captured load data.
- `ALU_result_out` out 32, `Dest_Reg_Addr_out` out 5: to MEM/WB.
- `misaligned_fault` out 1: one-cycle pulse.
- `bus_error` out 1: one-cycle pulse. Always 0 when the macro is undefined.

## Operation
- An access is `MemRead_in | MemWrite_in`. `MemWrite_in` wins if both are set.
- Aligned means `ALU_result_in[1:0]==0`.
- FSM states: IDLE, BUSY, DONE.
- IDLE, with an aligned access present:
  - `stall`=1 combinationally.
  - Next state BUSY.
  - Latch address, write data and write enable into the bus registers.
- IDLE, with no access: pass-through. `stall`=0, outputs follow inputs combinationally.
- IDLE, with a misaligned access:
  - No request and no stall.
  - `misaligned_fault`=1 for that cycle.
  - `RegWrite_out` forced 0.
  - State stays IDLE.
- BUSY:
  - `mem_req`=1 with `mem_addr`, `mem_wdata`, `mem_we` stable; `stall`=1.
  - On `mem_ack`=1: capture `mem_rdata` into `read_data_out` (reads only; writes leave it unchanged). Drop `mem_req` next cycle and go to DONE.
- DONE:
  - `stall`=0 and `mem_req`=0. MEM/WB captures the outputs at the end of this cycle.
  - The access still visible on the inputs is not restarted.
  - Next state is always IDLE.
- `mem_ack` is ignored outside BUSY.
- `RegWrite_out`, `MemtoReg_out`, `ALU_result_out`, `Dest_Reg_Addr_out` and `PCsrc_out` are combinational from the inputs, except for the forcing rules above.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `read_data_out`=0, `misaligned_fault`=0, `bus_error`=0, timeout counter=0.
- Reset in BUSY drops `mem_req` immediately, without waiting for a clock edge.
- Non-memory instruction: 0 added cycles.
- Memory access with ack k cycles after `mem_req` rises (k≥0): `stall` is high for k+2 cycles, covering the IDLE detect cycle and BUSY. DONE adds 1 cycle. Total k+3 cycles in the stage.
- Ack in the first BUSY cycle (k=0): `mem_req` is high for exactly 1 cycle.
- Back-to-back accesses: DONE→IDLE→BUSY. `mem_req` is low for at least 2 cycles between transfers.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`-1 without ack: `mem_req` drops and the FSM goes to DONE.
  - In that DONE cycle: `bus_error`=1, `read_data_out`=0, `RegWrite_out` forced 0.
  - The counter clears on entering BUSY.
- `MEM_ACCESS_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely, `bus_error` is tied to 0.

## Test plan
- Load, ack 2 cycles after req (addr=0x100, `mem_rdata`=0xDEADBEEF). Expect `stall` high 4 cycles, `mem_req` high 3 cycles, `mem_we`=0, DONE cycle `read_data_out`=0xDEADBEEF, `RegWrite_out`=1.
- Store with immediate ack (addr=0x204, data=0x12345678). Expect `mem_we`=1, `mem_wdata`=0x12345678, `mem_req` high 1 cycle, `stall` high 2 cycles, `read_data_out` unchanged.
- ALU instruction (`MemRead`=`MemWrite`=0, result=0x55, dest=7). Expect `stall`=0, `mem_req`=0, same-cycle `ALU_result_out`=0x55, `Dest_Reg_Addr_out`=7.
- Misaligned load at addr=0x102. Expect `misaligned_fault` pulse 1 cycle, `mem_req`=0, `stall`=0, `RegWrite_out`=0.
- Reset asserted 1 cycle into BUSY. Expect `mem_req`=0 before the next edge, state IDLE, `read_data_out`=0; a later load completes normally.
- With `MEM_ACCESS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack. Expect `mem_req` high 4 cycles, then `bus_error` pulse, `read_data_out`=0, `RegWrite_out`=0, `stall` released.
